// File: rtl/axi_rd_responder.sv
`timescale 1ns/1ps
// axi_rd_responder
// AXI4 read-channel responder (memory side). Accepts one AR burst at a time,
// reads each beat from a word-wide synchronous-read memory and returns it on R.
// FIXED and INCR bursts are served. Oversized beats (size>3) and WRAP/reserved
// bursts get SLVERR beats with zero data and no memory access.
//
// Optional feature: define AXI_RD_RESP_ADDR_CHECK_EN to answer any beat whose
// address lies outside [MemBase, MemBase+MemSize) with DECERR (no memory
// access). DECERR wins over SLVERR. Without it every supported beat reads
// memory and the word index simply aliases.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   ar_*                  AR channel (valid/ready, id, addr, len, size, burst)
//   r_*                   R channel (valid/ready, id, data, resp, last)
//   mem_req_o/mem_addr_o  memory read strobe and word index
//   mem_rdata_i           memory data, valid one cycle after mem_req_o
module axi_rd_responder #(
  parameter int unsigned AxiIdWidth   = 4,
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned MemAddrWidth = 16,
  parameter logic [AxiAddrWidth-1:0] MemBase = 'h8000_0000,
  parameter logic [AxiAddrWidth-1:0] MemSize = 'h4000_0000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    ar_valid_i,
  output logic                    ar_ready_o,
  input  logic [AxiIdWidth-1:0]   ar_id_i,
  input  logic [AxiAddrWidth-1:0] ar_addr_i,
  input  logic [7:0]              ar_len_i,
  input  logic [2:0]              ar_size_i,
  input  logic [1:0]              ar_burst_i,
  output logic                    r_valid_o,
  input  logic                    r_ready_i,
  output logic [AxiIdWidth-1:0]   r_id_o,
  output logic [AxiDataWidth-1:0] r_data_o,
  output logic [1:0]              r_resp_o,
  output logic                    r_last_o,
  output logic                    mem_req_o,
  output logic [MemAddrWidth-1:0] mem_addr_o,
  input  logic [AxiDataWidth-1:0] mem_rdata_i
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StResp = 2'd3;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  localparam logic [1:0] BurstFixed = 2'b00;

  logic [1:0]              state_q, state_d;
  logic [AxiIdWidth-1:0]   id_q, id_d;
  logic [AxiAddrWidth-1:0] addr_q, addr_d;
  logic [7:0]              len_q, len_d;
  logic [2:0]              size_q, size_d;
  logic [1:0]              burst_q, burst_d;
  logic [7:0]              beat_q, beat_d;
  logic [1:0]              resp_q, resp_d;
  logic                    r_valid_q, r_valid_d;
  logic [AxiIdWidth-1:0]   r_id_q, r_id_d;
  logic [AxiDataWidth-1:0] r_data_q, r_data_d;
  logic [1:0]              r_resp_q, r_resp_d;
  logic                    r_last_q, r_last_d;
  logic                    mem_req_q, mem_req_d;
  logic [MemAddrWidth-1:0] mem_addr_q, mem_addr_d;

  logic                    load_beat;
  logic [1:0]              beat_resp;
  logic [AxiAddrWidth-1:0] step;

  function automatic logic [MemAddrWidth-1:0] word_idx(input logic [AxiAddrWidth-1:0] a);
    return MemAddrWidth'((a - MemBase) >> 3);
  endfunction

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    addr_d     = addr_q;
    len_d      = len_q;
    size_d     = size_q;
    burst_d    = burst_q;
    beat_d     = beat_q;
    resp_d     = resp_q;
    r_valid_d  = r_valid_q;
    r_id_d     = r_id_q;
    r_data_d   = r_data_q;
    r_resp_d   = r_resp_q;
    r_last_d   = r_last_q;
    mem_req_d  = 1'b0;
    mem_addr_d = mem_addr_q;
    load_beat  = 1'b0;
    beat_resp  = RespOkay;
    step       = {{(AxiAddrWidth-1){1'b0}}, 1'b1} << size_q;

    case (state_q)
      StIdle: begin
        if (ar_valid_i) begin
          id_d      = ar_id_i;
          addr_d    = ar_addr_i;
          len_d     = ar_len_i;
          size_d    = ar_size_i;
          burst_d   = ar_burst_i;
          beat_d    = '0;
          load_beat = 1'b1;
          state_d   = StReq;
        end
      end
      StReq: state_d = StWait;
      StWait: begin
        r_valid_d = 1'b1;
        r_id_d    = id_q;
        r_data_d  = (resp_q == RespOkay) ? mem_rdata_i : '0;
        r_resp_d  = resp_q;
        r_last_d  = (beat_q == len_q);
        state_d   = StResp;
      end
      StResp: begin
        if (r_ready_i) begin
          r_valid_d = 1'b0;
          if (r_last_q) begin
            state_d = StIdle;
          end else begin
            beat_d = beat_q + 8'd1;
            if (burst_q != BurstFixed) begin
              // Non-FIXED bursts step like INCR so error beats still walk the
              // address range when the window check is compiled in.
              addr_d = (addr_q & ~(step - 1'b1)) + step;
            end
            load_beat = 1'b1;
            state_d   = StReq;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Classify the beat about to enter REQ; the memory strobe and word index
    // are registered here so they appear exactly during the REQ cycle.
    if (load_beat) begin
      if (size_d > 3'd3 || burst_d[1]) begin
        beat_resp = RespSlvErr;
      end
`ifdef AXI_RD_RESP_ADDR_CHECK_EN
      if ((addr_d - MemBase) >= MemSize) begin
        beat_resp = RespDecErr;
      end
`endif
      resp_d     = beat_resp;
      mem_req_d  = (beat_resp == RespOkay);
      mem_addr_d = word_idx(addr_d);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      beat_q     <= '0;
      resp_q     <= '0;
      r_valid_q  <= 1'b0;
      r_id_q     <= '0;
      r_data_q   <= '0;
      r_resp_q   <= '0;
      r_last_q   <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      beat_q     <= beat_d;
      resp_q     <= resp_d;
      r_valid_q  <= r_valid_d;
      r_id_q     <= r_id_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
      r_last_q   <= r_last_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign ar_ready_o = (state_q == StIdle) && !rst_i;
  assign r_valid_o  = r_valid_q;
  assign r_id_o     = r_id_q;
  assign r_data_o   = r_data_q;
  assign r_resp_o   = r_resp_q;
  assign r_last_o   = r_last_q;
  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = mem_addr_q;

endmodule

// File: tb/tb_axi_rd_responder.sv
`timescale 1ns/1ps
module tb_axi_rd_responder;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        ar_valid, ar_ready;
  logic [3:0]  ar_id;
  logic [63:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic        r_valid, r_ready;
  logic [3:0]  r_id;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [63:0] mem_rdata = '1;

  always #5 clk = ~clk;

  axi_rd_responder #(
    .AxiIdWidth(4),
    .AxiAddrWidth(64),
    .AxiDataWidth(64),
    .MemAddrWidth(16),
    .MemBase(64'h8000_0000),
    .MemSize(64'h4000_0000)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_id_i(ar_id),
    .ar_addr_i(ar_addr), .ar_len_i(ar_len), .ar_size_i(ar_size), .ar_burst_i(ar_burst),
    .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id), .r_data_o(r_data),
    .r_resp_o(r_resp), .r_last_o(r_last),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata)
  );

  function automatic logic [63:0] mdata(input logic [15:0] a);
    return 64'hA5A5_0000_0000_0000 | {48'h0, a};
  endfunction

  // Sync-read memory model: data only valid the cycle after a strobe.
  always @(posedge clk) mem_rdata <= mem_req ? mdata(mem_addr) : '1;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  rbeat_t      exp_r[$];
  logic [15:0] exp_mem[$];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string got, input string want);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %s expected %s", name, got, want);
  endtask

  task automatic push_r(input logic [3:0] id, input logic [63:0] data,
                        input logic [1:0] resp, input logic last);
    rbeat_t e;
    e.id = id; e.data = data; e.resp = resp; e.last = last;
    exp_r.push_back(e);
  endtask

  // Monitor: samples 1ns after each falling edge.
  rbeat_t cur, snap, e;
  logic   stalled = 1'b0;
  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (mem_req) begin
        if (exp_mem.size() == 0) fail("unexpected_mem_req", "strobe", "none");
        else chk("mem_addr", mem_addr, exp_mem.pop_front());
      end
      if (r_valid) begin
        cur = {r_id, r_data, r_resp, r_last};
        if (stalled) chk("r_stable", cur, snap);
        if (r_ready) begin
          stalled = 1'b0;
          if (exp_r.size() == 0) fail("unexpected_r_beat", "beat", "none");
          else begin
            e = exp_r.pop_front();
            chk("r_id", r_id, e.id);
            chk("r_data", r_data, e.data);
            chk("r_resp", r_resp, e.resp);
            chk("r_last", r_last, e.last);
          end
        end else begin
          stalled = 1'b1;
          snap = cur;
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  // Returns at the falling edge after the AR handshake edge.
  task automatic send_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int t = 0;
    @(negedge clk);
    ar_valid = 1'b1; ar_id = id; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst;
    #1;
    while (!ar_ready && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 100) fail("ar_timeout", "no ar_ready", "ar_ready");
    @(negedge clk);
    ar_valid = 1'b0;
  endtask

  task automatic wait_rvalid();
    int t = 0;
    @(negedge clk);
    #1;
    while (!r_valid && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 100) fail("rvalid_timeout", "no r_valid", "r_valid");
  endtask

  task automatic drain();
    int t = 0;
    @(negedge clk);
    #2;
    while ((exp_r.size() != 0 || exp_mem.size() != 0 || !ar_ready) && t < 300) begin
      @(negedge clk);
      #2;
      t++;
    end
    if (t >= 300) fail("drain_timeout", "pending beats", "idle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got hang expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ar_valid = 1'b0; ar_id = '0; ar_addr = '0; ar_len = '0;
    ar_size = '0; ar_burst = '0; r_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ar_ready", ar_ready, 0);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_r_id", r_id, 0);
    chk("rst_r_data", r_data, 0);
    chk("rst_r_resp", r_resp, 0);
    chk("rst_r_last", r_last, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ar_ready_after_rst", ar_ready, 1);

    // Single beat with latency checks.
    exp_mem.push_back(16'd2);
    push_r(4'd5, mdata(16'd2), OKAY, 1'b1);
    send_ar(4'd5, 64'h8000_0010, 8'd0, 3'd3, 2'b01);
    #1;
    chk("lat_mem_req_n1", mem_req, 1);
    chk("ar_ready_busy", ar_ready, 0);
    @(negedge clk); #1;
    chk("lat_r_valid_n2", r_valid, 0);
    @(negedge clk); #1;
    chk("lat_r_valid_n3", r_valid, 1);
    drain();

    // INCR len 3 with a 4-cycle stall on beat 1.
    for (int i = 0; i < 4; i++) begin
      exp_mem.push_back(16'(i));
      push_r(4'd3, mdata(16'(i)), OKAY, i == 3);
    end
    r_ready = 1'b0;
    send_ar(4'd3, 64'h8000_0000, 8'd3, 3'd3, 2'b01);
    wait_rvalid();
    @(negedge clk); r_ready = 1'b1;
    @(negedge clk); r_ready = 1'b0;
    wait_rvalid();
    repeat (4) @(negedge clk);
    r_ready = 1'b1;
    drain();

    // FIXED len 2 size 2: same word three times.
    for (int i = 0; i < 3; i++) begin
      exp_mem.push_back(16'd1);
      push_r(4'd7, mdata(16'd1), OKAY, i == 2);
    end
    send_ar(4'd7, 64'h8000_0008, 8'd2, 3'd2, 2'b00);
    drain();

    // INCR size 2 from 0x..04 crosses into the next word.
    exp_mem.push_back(16'd0);
    exp_mem.push_back(16'd1);
    push_r(4'd2, mdata(16'd0), OKAY, 1'b0);
    push_r(4'd2, mdata(16'd1), OKAY, 1'b1);
    send_ar(4'd2, 64'h8000_0004, 8'd1, 3'd2, 2'b01);
    drain();

    // Error bursts: WRAP, oversized beat, reserved burst type.
    push_r(4'd9, '0, SLVERR, 1'b0);
    push_r(4'd9, '0, SLVERR, 1'b1);
    send_ar(4'd9, 64'h8000_0000, 8'd1, 3'd3, 2'b10);
    drain();
    push_r(4'd10, '0, SLVERR, 1'b0);
    push_r(4'd10, '0, SLVERR, 1'b1);
    send_ar(4'd10, 64'h8000_0000, 8'd1, 3'd4, 2'b01);
    drain();
    push_r(4'd11, '0, SLVERR, 1'b1);
    send_ar(4'd11, 64'h8000_0020, 8'd0, 3'd3, 2'b11);
    drain();

    // Window boundary and out-of-window address.
`ifdef AXI_RD_RESP_ADDR_CHECK_EN
    exp_mem.push_back(16'hFFFF);
    push_r(4'd1, mdata(16'hFFFF), OKAY, 1'b0);
    push_r(4'd1, '0, DECERR, 1'b1);
    send_ar(4'd1, 64'hBFFF_FFF8, 8'd1, 3'd3, 2'b01);
    drain();
    push_r(4'd12, '0, DECERR, 1'b1);
    send_ar(4'd12, 64'h0, 8'd0, 3'd3, 2'b01);
    drain();
`else
    exp_mem.push_back(16'hFFFF);
    exp_mem.push_back(16'h0000);
    push_r(4'd1, mdata(16'hFFFF), OKAY, 1'b0);
    push_r(4'd1, mdata(16'h0000), OKAY, 1'b1);
    send_ar(4'd1, 64'hBFFF_FFF8, 8'd1, 3'd3, 2'b01);
    drain();
    exp_mem.push_back(16'h0000);
    push_r(4'd12, mdata(16'h0000), OKAY, 1'b1);
    send_ar(4'd12, 64'h0, 8'd0, 3'd3, 2'b01);
    drain();
`endif

    // Reset while beat 1 of 4 waits in RESP.
    exp_mem.push_back(16'd0);
    exp_mem.push_back(16'd1);
    push_r(4'd4, mdata(16'd0), OKAY, 1'b0);
    r_ready = 1'b0;
    send_ar(4'd4, 64'h8000_0000, 8'd3, 3'd3, 2'b01);
    wait_rvalid();
    @(negedge clk); r_ready = 1'b1;
    @(negedge clk); r_ready = 1'b0;
    wait_rvalid();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1;
    chk("midrst_r_valid", r_valid, 0);
    chk("midrst_ar_ready", ar_ready, 0);
    @(negedge clk); rst = 1'b0; r_ready = 1'b1;
    #1;
    chk("postrst_ar_ready", ar_ready, 1);
    chk("postrst_pending", exp_r.size() + exp_mem.size(), 0);
    repeat (6) @(negedge clk);
    exp_mem.push_back(16'd3);
    push_r(4'd6, mdata(16'd3), OKAY, 1'b1);
    send_ar(4'd6, 64'h8000_0018, 8'd0, 3'd3, 2'b01);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
